// File: rtl/serial_receiver.sv
// 8N1 UART receiver that reassembles 11-byte triad packets (header, 9 payload bytes, XOR checksum).
// data_avl and the other strobes rise one cycle after the deciding stop-bit sample; there is no backpressure, and the host must take each strobe as it fires.
module serial_receiver #(
  parameter int         CLKS_PER_BIT = 104,
  parameter logic [7:0] HEADER_BYTE  = 8'hA5,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic        clk_12MHz,
  input  logic        reset,
  input  logic        rx,
  output logic [67:0] triad_data,
  output logic        reset_pulse_identifier,
  output logic        data_avl,
  output logic        frame_error,
  output logic        checksum_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} byte_state_t;
  typedef enum logic [1:0] {P_WAIT_HDR, P_PAYLOAD, P_CHECK} pkt_state_t;

  logic             rx_meta, rx_sync;
  byte_state_t      b_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_dat;
  logic             byte_vld, stop_bad;

  pkt_state_t       p_state;
  logic [3:0]       p_idx;
  logic [7:0]       xor_acc;
  logic             rpi_asm;
  logic [67:0]      trd_asm;
  logic [TO_W-1:0]  to_cnt;

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // The completed byte is presented in the same cycle as its stop-bit sample.
  assign byte_vld = (b_state == B_STOP) && (bit_cnt == BIT_LAST) && rx_sync;
  assign stop_bad = (b_state == B_STOP) && (bit_cnt == BIT_LAST) && !rx_sync;

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      b_state     <= B_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_dat   <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (b_state)
        B_IDLE: begin
          bit_cnt <= '0;
          if (!rx_sync) b_state <= B_START;
        end
        B_START: begin
          if (bit_cnt == HALF) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            b_state <= rx_sync ? B_IDLE : B_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            shift_dat <= {rx_sync, shift_dat[7:1]};
            if (bit_idx == 3'd7) b_state <= B_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (rx_sync) begin
              b_state <= B_IDLE;
            end else begin
              frame_error <= 1'b1;
              b_state     <= B_BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // A low stop bit may be a break; re-arm only once the line returns high.
        B_BREAK: if (rx_sync) b_state <= B_IDLE;
        default: b_state <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      p_state                <= P_WAIT_HDR;
      p_idx                  <= '0;
      xor_acc                <= '0;
      rpi_asm                <= 1'b0;
      trd_asm                <= '0;
      to_cnt                 <= '0;
      triad_data             <= '0;
      reset_pulse_identifier <= 1'b0;
      data_avl               <= 1'b0;
      checksum_error         <= 1'b0;
    end else begin
      data_avl       <= 1'b0;
      checksum_error <= 1'b0;

      if (p_state == P_WAIT_HDR || byte_vld) to_cnt <= '0;
      else if (to_cnt != TO_LAST)            to_cnt <= to_cnt + 1'b1;

      if (stop_bad) begin
        p_state <= P_WAIT_HDR;
      end else if (byte_vld) begin
        case (p_state)
          P_WAIT_HDR: begin
            if (shift_dat == HEADER_BYTE) begin
              p_state <= P_PAYLOAD;
              p_idx   <= '0;
              xor_acc <= '0;
            end
          end
          P_PAYLOAD: begin
            xor_acc <= xor_acc ^ shift_dat;
            // First payload byte carries the flag, three padding bits, then triad_data[67:64].
            if (p_idx == 4'd0) begin
              rpi_asm <= shift_dat[7];
              trd_asm <= {64'd0, shift_dat[3:0]};
            end else begin
              trd_asm <= {trd_asm[59:0], shift_dat};
            end
            if (p_idx == 4'd8) p_state <= P_CHECK;
            else               p_idx   <= p_idx + 4'd1;
          end
          P_CHECK: begin
            if (shift_dat == xor_acc) begin
              triad_data             <= trd_asm;
              reset_pulse_identifier <= rpi_asm;
              data_avl               <= 1'b1;
            end else begin
              checksum_error <= 1'b1;
            end
            p_state <= P_WAIT_HDR;
          end
          default: p_state <= P_WAIT_HDR;
        endcase
      end else if (p_state != P_WAIT_HDR && to_cnt == TO_LAST) begin
        p_state <= P_WAIT_HDR;
      end
    end
  end

endmodule
